// File: rtl/ft_input_packer.sv
// ft_input_packer: frames the FT245 receive byte stream into command/address/data packets.
// A packet is 0xCD, a 32-bit command, a 32-bit address and N data words, all MSB first;
// N = command[27:0]. Each completed word is handed to the wishbone master with an ih_ready
// pulse. Define FT_INPUT_TIMEOUT_EN to abort partial packets after TIMEOUT_CYCLES idle clocks.
module ft_input_packer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned ERR_CNT_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               byte_i,
    input  logic                     byte_valid_i,
    output logic                     byte_ready_o,
    input  logic                     master_ready,
    output logic                     ih_ready,
    output logic [31:0]              in_command,
    output logic [31:0]              in_address,
    output logic [27:0]              in_data_count,
    output logic [31:0]              in_data,
    output logic                     busy_o,
    output logic [ERR_CNT_WIDTH-1:0] sync_err_cnt
);

    typedef enum logic [1:0] {StIdle, StCmd, StAddr, StData} state_e;

    state_e      state;
    logic        word_pending;
    logic        byte_ready_q;
    logic [1:0]  byte_idx;
    logic [27:0] words_left;

    logic accept;
    logic pulse;
    logic err_sat;

    assign accept       = byte_valid_i & byte_ready_q;
    // The master sees the word in the first cycle it is ready; the holding register frees then.
    assign pulse        = word_pending & master_ready;
    assign ih_ready     = pulse;
    assign byte_ready_o = byte_ready_q;
    assign busy_o       = (state != StIdle);
    assign err_sat      = &sync_err_cnt;

`ifdef FT_INPUT_TIMEOUT_EN
    logic [31:0] idle_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Packet framing FSM with the single word holding register and error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            word_pending  <= 1'b0;
            byte_ready_q  <= 1'b0;
            byte_idx      <= 2'd0;
            words_left    <= 28'd0;
            in_command    <= 32'd0;
            in_address    <= 32'd0;
            in_data_count <= 28'd0;
            in_data       <= 32'd0;
            sync_err_cnt  <= '0;
`ifdef FT_INPUT_TIMEOUT_EN
            idle_cnt      <= 32'd0;
`endif
        end else begin
            // Ready stays low while a word waits; it returns the cycle after the pulse.
            byte_ready_q <= ~word_pending | pulse;

            if (pulse) begin
                word_pending <= 1'b0;
                if (words_left == 28'd0) begin
                    state <= StIdle;
                end
            end

            if (accept) begin
                byte_idx <= byte_idx + 2'd1;
                unique case (state)
                    StIdle: begin
                        if (byte_i == 8'hCD) begin
                            state    <= StCmd;
                            byte_idx <= 2'd0;
                        end else if (!err_sat) begin
                            sync_err_cnt <= sync_err_cnt + 1'b1;
                        end
                    end
                    StCmd: begin
                        in_command <= {in_command[23:0], byte_i};
                        if (byte_idx == 2'd3) begin
                            in_data_count <= {in_command[19:0], byte_i};
                            state         <= StAddr;
                        end
                    end
                    StAddr: begin
                        in_address <= {in_address[23:0], byte_i};
                        if (byte_idx == 2'd3) begin
                            state      <= StData;
                            words_left <= in_data_count;
                            // An empty packet still produces one pulse carrying zero data.
                            if (in_data_count == 28'd0) begin
                                word_pending <= 1'b1;
                                byte_ready_q <= 1'b0;
                                in_data      <= 32'd0;
                            end
                        end
                    end
                    StData: begin
                        in_data <= {in_data[23:0], byte_i};
                        if (byte_idx == 2'd3) begin
                            word_pending <= 1'b1;
                            byte_ready_q <= 1'b0;
                            if (words_left != 28'd0) begin
                                words_left <= words_left - 28'd1;
                            end
                        end
                    end
                    default: state <= StIdle;
                endcase
            end

`ifdef FT_INPUT_TIMEOUT_EN
            // Idle clocks inside a packet count toward abort; a waiting word never times out.
            if (accept || pulse) begin
                idle_cnt <= 32'd0;
            end else if (state != StIdle && !byte_valid_i && !word_pending) begin
                if (idle_cnt == TIMEOUT_CYCLES - 1) begin
                    state    <= StIdle;
                    byte_idx <= 2'd0;
                    idle_cnt <= 32'd0;
                    if (!err_sat) begin
                        sync_err_cnt <= sync_err_cnt + 1'b1;
                    end
                end else begin
                    idle_cnt <= idle_cnt + 32'd1;
                end
            end
`endif
        end
    end

endmodule
